// File: rtl/sd_access_arbiter.sv
// sd_access_arbiter: round-robin owner of the single SD controller.
// A requester raises REQ with its address/data. It is granted in turn.
// The arbiter then drives the controller's read/write command level and
// returns a one-cycle DONE pulse, or an ERR pulse if the command is never
// accepted within ISSUE_TMO cycles.
module sd_access_arbiter #(
    parameter int N_REQ     = 2,
    parameter int DW        = 16,
    parameter int ISSUE_TMO = 1024
) (
    input  logic                  CLK,
    input  logic                  RESET_n,
    input  logic [N_REQ-1:0]      REQ,
    input  logic [N_REQ-1:0]      REQ_WE,
    input  logic [32*N_REQ-1:0]   REQ_ADDR,
    input  logic [DW*N_REQ-1:0]   REQ_WDATA,
    output logic [N_REQ-1:0]      GNT,
    output logic [N_REQ-1:0]      DONE,
    output logic [N_REQ-1:0]      ERR,
    input  logic                  SD_HAS_INITIALIZED,
    input  logic                  SD_IS_READING,
    input  logic                  SD_IS_WRITING,
    output logic                  SD_TO_READ,
    output logic                  SD_TO_WRITE,
    output logic [31:0]           SD_READ_ADDRESS,
    output logic [31:0]           SD_WRITE_ADDRESS,
    output logic [DW-1:0]         SD_DATA_TO_WRITE
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(ISSUE_TMO) + 1;

    typedef enum logic [2:0] {
        WAIT_INIT,
        IDLE,
        ISSUE,
        BUSY,
        FINISH
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic            we;
    logic            tmo_err;
    logic [CW-1:0]   cnt;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic            busy_sel;
    logic            tmo_hit;

    // Requester index k places after the round-robin pointer, wrapping.
    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] p, input int k);
        int j;
        j = int'(p) + k;
        if (j >= N_REQ) j = j - N_REQ;
        return IW'(j);
    endfunction

    // Busy flag that matches the direction of the current transaction.
    assign busy_sel = we ? SD_IS_WRITING : SD_IS_READING;
    // Last cycle of the command window; leaving ISSUE here without busy means timeout.
    assign tmo_hit  = (cnt == CW'(ISSUE_TMO - 1));

    // Round-robin pick: scan backwards so the nearest requester at/after ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (REQ[rr_index(ptr, k)]) begin
                pick_vld = 1'b1;
                pick_idx = rr_index(ptr, k);
            end
        end
    end

    // State register; only reset returns the arbiter to WAIT_INIT.
    always_ff @(posedge CLK) begin
        if (!RESET_n) state <= WAIT_INIT;
        else          state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            WAIT_INIT: if (SD_HAS_INITIALIZED) state_nx = IDLE;
            IDLE:      if (pick_vld) state_nx = ISSUE;
            ISSUE: begin
                if (busy_sel)     state_nx = BUSY;
                else if (tmo_hit) state_nx = FINISH;
            end
            BUSY:      if (!busy_sel) state_nx = FINISH;
            FINISH:    state_nx = IDLE;
            default:   state_nx = WAIT_INIT;
        endcase
    end

    // Transaction context: latched at grant, timeout counter, fairness pointer.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            ptr              <= '0;
            idx              <= '0;
            we               <= 1'b0;
            tmo_err          <= 1'b0;
            cnt              <= '0;
            SD_READ_ADDRESS  <= '0;
            SD_WRITE_ADDRESS <= '0;
            SD_DATA_TO_WRITE <= '0;
        end else begin
            if (state == IDLE && pick_vld) begin
                idx     <= pick_idx;
                we      <= REQ_WE[pick_idx];
                tmo_err <= 1'b0;
                cnt     <= '0;
                if (REQ_WE[pick_idx]) begin
                    SD_WRITE_ADDRESS <= REQ_ADDR[32*pick_idx +: 32];
                    SD_DATA_TO_WRITE <= REQ_WDATA[DW*pick_idx +: DW];
                end else begin
                    SD_READ_ADDRESS  <= REQ_ADDR[32*pick_idx +: 32];
                end
            end
            if (state == ISSUE && cnt != {CW{1'b1}}) cnt <= cnt + 1'b1;
            if (state == ISSUE && !busy_sel && tmo_hit) tmo_err <= 1'b1;
            if (state == FINISH) ptr <= (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
        end
    end

    // Outputs decoded from state: grant spans ISSUE/BUSY, pulses come from FINISH.
    always_comb begin
        GNT         = '0;
        DONE        = '0;
        ERR         = '0;
        SD_TO_READ  = 1'b0;
        SD_TO_WRITE = 1'b0;
        case (state)
            ISSUE: begin
                GNT[idx]    = 1'b1;
                SD_TO_READ  = !we;
                SD_TO_WRITE = we;
            end
            BUSY:   GNT[idx] = 1'b1;
            FINISH: begin
                if (tmo_err) ERR[idx]  = 1'b1;
                else         DONE[idx] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Bench for sd_access_arbiter: directed requests, a small SD controller
// responder, and a scoreboard monitor checking grants and completions.
module tb_sd_access_arbiter;

    localparam int N_REQ = 2;
    localparam int DW    = 16;
    localparam int TMO   = 16;

    logic                CLK;
    logic                RESET_n;
    logic [N_REQ-1:0]    REQ;
    logic [N_REQ-1:0]    REQ_WE;
    logic [32*N_REQ-1:0] REQ_ADDR;
    logic [DW*N_REQ-1:0] REQ_WDATA;
    logic [N_REQ-1:0]    GNT;
    logic [N_REQ-1:0]    DONE;
    logic [N_REQ-1:0]    ERR;
    logic                SD_HAS_INITIALIZED;
    logic                SD_IS_READING;
    logic                SD_IS_WRITING;
    logic                SD_TO_READ;
    logic                SD_TO_WRITE;
    logic [31:0]         SD_READ_ADDRESS;
    logic [31:0]         SD_WRITE_ADDRESS;
    logic [DW-1:0]       SD_DATA_TO_WRITE;

    sd_access_arbiter #(.N_REQ(N_REQ), .DW(DW), .ISSUE_TMO(TMO)) dut (
        .CLK                (CLK),
        .RESET_n            (RESET_n),
        .REQ                (REQ),
        .REQ_WE             (REQ_WE),
        .REQ_ADDR           (REQ_ADDR),
        .REQ_WDATA          (REQ_WDATA),
        .GNT                (GNT),
        .DONE               (DONE),
        .ERR                (ERR),
        .SD_HAS_INITIALIZED (SD_HAS_INITIALIZED),
        .SD_IS_READING      (SD_IS_READING),
        .SD_IS_WRITING      (SD_IS_WRITING),
        .SD_TO_READ         (SD_TO_READ),
        .SD_TO_WRITE        (SD_TO_WRITE),
        .SD_READ_ADDRESS    (SD_READ_ADDRESS),
        .SD_WRITE_ADDRESS   (SD_WRITE_ADDRESS),
        .SD_DATA_TO_WRITE   (SD_DATA_TO_WRITE)
    );

    typedef struct {
        logic [1:0]  gnt;
        logic        we;
    } gnt_t;

    typedef struct {
        logic [1:0]  done;
        logic [1:0]  err;
        logic [31:0] rd;
        logic [31:0] wr;
        logic [15:0] wd;
        int          cmd;
    } resp_t;

    gnt_t        gnt_q[$];
    resp_t       resp_q[$];
    logic [31:0] sh_rd, sh_wr;
    logic [15:0] sh_wd;
    int          errors = 0;
    int          checks = 0;
    logic        model_never = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_gnt(input int i, input logic w);
        gnt_t g;
        g.gnt = 2'b01 << i;
        g.we  = w;
        gnt_q.push_back(g);
    endtask

    task automatic push(input int i, input logic w, input logic [31:0] a,
                        input logic [15:0] d, input logic is_err, input int cmd);
        resp_t r;
        push_gnt(i, w);
        if (w) begin
            sh_wr = a;
            sh_wd = d;
        end else begin
            sh_rd = a;
        end
        r.done = is_err ? 2'b00 : 2'b01 << i;
        r.err  = is_err ? 2'b01 << i : 2'b00;
        r.rd   = sh_rd;
        r.wr   = sh_wr;
        r.wd   = sh_wd;
        r.cmd  = cmd;
        resp_q.push_back(r);
    endtask

    task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [15:0] d);
        REQ[i]               = 1'b1;
        REQ_WE[i]            = w;
        REQ_ADDR[32*i +: 32] = a;
        REQ_WDATA[16*i +: 16] = d;
    endtask

    // Waits for the next DONE/ERR pulse selected by mask; a missing pulse is a failed check.
    task automatic wait_resp(input logic [1:0] mask, input int max);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (((DONE | ERR) & mask) == 2'b00 && n < max);
        if (((DONE | ERR) & mask) == 2'b00) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got none expected pulse on mask %0b", mask);
        end
    endtask

    // SD controller responder: busy rises 3 cycles after the command, lasts 20 cycles.
    initial begin
        logic is_wr;
        SD_IS_READING = 1'b0;
        SD_IS_WRITING = 1'b0;
        forever begin
            @(negedge CLK);
            if (RESET_n && (SD_TO_READ || SD_TO_WRITE) && !model_never) begin
                is_wr = SD_TO_WRITE;
                repeat (2) @(negedge CLK);
                if (is_wr) SD_IS_WRITING = 1'b1;
                else       SD_IS_READING = 1'b1;
                repeat (20) @(negedge CLK);
                SD_IS_WRITING = 1'b0;
                SD_IS_READING = 1'b0;
            end
        end
    end

    // Monitor: pops expected grants on GNT rising and expected completions on DONE/ERR.
    initial begin
        logic [1:0] gnt_prev;
        int         cmd_cnt;
        gnt_t       g;
        resp_t      r;
        gnt_prev = '0;
        cmd_cnt  = 0;
        forever begin
            @(negedge CLK);
            if (SD_TO_READ || SD_TO_WRITE) cmd_cnt++;
            if (GNT != 2'b00 && gnt_prev == 2'b00) begin
                cmd_cnt = (SD_TO_READ || SD_TO_WRITE) ? 1 : 0;
                if (gnt_q.size() == 0) begin
                    chk("unexpected_gnt", 64'(GNT), 64'h0);
                end else begin
                    g = gnt_q.pop_front();
                    chk("gnt", 64'(GNT), 64'(g.gnt));
                    chk("cmd_write", 64'(SD_TO_WRITE), 64'(g.we));
                    chk("cmd_read", 64'(SD_TO_READ), 64'(!g.we));
                end
            end
            if ((DONE | ERR) != 2'b00) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp", 64'({DONE, ERR}), 64'h0);
                end else begin
                    r = resp_q.pop_front();
                    chk("done", 64'(DONE), 64'(r.done));
                    chk("err", 64'(ERR), 64'(r.err));
                    chk("gnt_at_resp", 64'(GNT), 64'h0);
                    chk("rd_addr", 64'(SD_READ_ADDRESS), 64'(r.rd));
                    chk("wr_addr", 64'(SD_WRITE_ADDRESS), 64'(r.wr));
                    chk("wdata", 64'(SD_DATA_TO_WRITE), 64'(r.wd));
                    chk("cmd_cycles", 64'(cmd_cnt), 64'(r.cmd));
                end
            end
            gnt_prev = GNT;
        end
    end

    initial begin
        RESET_n            = 1'b0;
        SD_HAS_INITIALIZED = 1'b0;
        REQ                = '0;
        REQ_WE             = '0;
        REQ_ADDR           = '0;
        REQ_WDATA          = '0;
        sh_rd = '0;
        sh_wr = '0;
        sh_wd = '0;
        repeat (3) @(negedge CLK);
        chk("rst_gnt", 64'(GNT), 64'h0);
        chk("rst_done", 64'(DONE), 64'h0);
        chk("rst_err", 64'(ERR), 64'h0);
        chk("rst_to_read", 64'(SD_TO_READ), 64'h0);
        chk("rst_to_write", 64'(SD_TO_WRITE), 64'h0);
        chk("rst_rd_addr", 64'(SD_READ_ADDRESS), 64'h0);
        chk("rst_wr_addr", 64'(SD_WRITE_ADDRESS), 64'h0);
        chk("rst_wdata", 64'(SD_DATA_TO_WRITE), 64'h0);

        // Test 1: request while controller not initialised.
        RESET_n = 1'b1;
        set_req(0, 1'b0, 32'h0000_0040, 16'h0);
        for (int c = 1; c <= 50; c++) begin
            @(negedge CLK);
            if (c % 10 == 0) begin
                chk("t1_gnt_hold", 64'(GNT), 64'h0);
                chk("t1_cmd_hold", 64'({SD_TO_READ, SD_TO_WRITE}), 64'h0);
            end
        end
        push(0, 1'b0, 32'h0000_0040, 16'h0, 1'b0, 3);
        SD_HAS_INITIALIZED = 1'b1;
        @(negedge CLK);
        chk("t1_gnt_idle", 64'(GNT), 64'h0);
        @(negedge CLK);
        chk("t1_gnt", 64'(GNT), 64'h1);
        wait_resp(2'b01, 200);
        REQ[0] = 1'b0;

        // Test 2: requester 1 read.
        set_req(1, 1'b0, 32'h0000_0100, 16'h0);
        push(1, 1'b0, 32'h0000_0100, 16'h0, 1'b0, 3);
        wait_resp(2'b10, 200);
        REQ[1] = 1'b0;

        // Test 3: both requesting continuously; grants must alternate.
        set_req(0, 1'b0, 32'h0000_0300, 16'h0);
        set_req(1, 1'b1, 32'h0000_0400, 16'hBEEF);
        push(0, 1'b0, 32'h0000_0300, 16'h0, 1'b0, 3);
        push(1, 1'b1, 32'h0000_0400, 16'hBEEF, 1'b0, 3);
        push(0, 1'b0, 32'h0000_0300, 16'h0, 1'b0, 3);
        push(1, 1'b1, 32'h0000_0400, 16'hBEEF, 1'b0, 3);
        for (int t = 0; t < 4; t++) wait_resp(2'b11, 200);
        REQ = '0;

        // Test 4: requester 0 write; read address must hold.
        set_req(0, 1'b1, 32'h0000_0200, 16'h1234);
        push(0, 1'b1, 32'h0000_0200, 16'h1234, 1'b0, 3);
        wait_resp(2'b01, 200);
        REQ[0] = 1'b0;

        // Test 5: controller never accepts -> ERR, then next request served.
        model_never = 1'b1;
        set_req(0, 1'b0, 32'h0000_0500, 16'h0);
        push(0, 1'b0, 32'h0000_0500, 16'h0, 1'b1, TMO);
        wait_resp(2'b01, 200);
        REQ[0] = 1'b0;
        model_never = 1'b0;
        set_req(1, 1'b0, 32'h0000_0600, 16'h0);
        push(1, 1'b0, 32'h0000_0600, 16'h0, 1'b0, 3);
        wait_resp(2'b10, 200);
        REQ[1] = 1'b0;

        // Test 6: reset while BUSY abandons the transaction.
        set_req(0, 1'b0, 32'h0000_0700, 16'h0);
        push_gnt(0, 1'b0);
        repeat (10) @(negedge CLK);
        chk("t6_gnt_busy", 64'(GNT), 64'h1);
        RESET_n = 1'b0;
        @(negedge CLK);
        chk("t6_gnt", 64'(GNT), 64'h0);
        chk("t6_done_err", 64'({DONE, ERR}), 64'h0);
        chk("t6_cmd", 64'({SD_TO_READ, SD_TO_WRITE}), 64'h0);
        chk("t6_rd_addr", 64'(SD_READ_ADDRESS), 64'h0);
        chk("t6_wr_addr", 64'(SD_WRITE_ADDRESS), 64'h0);
        chk("t6_wdata", 64'(SD_DATA_TO_WRITE), 64'h0);
        REQ = '0;
        sh_rd = '0;
        sh_wr = '0;
        sh_wd = '0;
        SD_HAS_INITIALIZED = 1'b0;
        RESET_n = 1'b1;
        set_req(1, 1'b0, 32'h0000_0800, 16'h0);
        for (int c = 1; c <= 30; c++) begin
            @(negedge CLK);
            if (c % 10 == 0) chk("t6_wait_init", 64'(GNT), 64'h0);
        end
        push(1, 1'b0, 32'h0000_0800, 16'h0, 1'b0, 3);
        SD_HAS_INITIALIZED = 1'b1;
        wait_resp(2'b10, 200);
        REQ[1] = 1'b0;

        repeat (5) @(negedge CLK);
        chk("gnt_q_empty", 64'(gnt_q.size()), 64'h0);
        chk("resp_q_empty", 64'(resp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
